// File: rtl/viola_pkg.sv
// Shared definitions for the result-writeback path: bus widths, the null
// ROB tag and the source encoding used on the common data bus.
package viola_pkg;

  localparam int TAG_W  = 3;
  localparam int DATA_W = 32;

  localparam logic [TAG_W-1:0] NULL_TAG = '0;

  localparam logic SRC_ALU = 1'b0;
  localparam logic SRC_MEM = 1'b1;

  // Round-robin pick between the two FIFO heads. When both are waiting, the
  // source that did not win last time gets the bus.
  function automatic logic pick_src(input logic alu_ne, input logic mem_ne,
                                    input logic rr_last);
    if (alu_ne && mem_ne) return ~rr_last;
    if (alu_ne)           return SRC_ALU;
    return SRC_MEM;
  endfunction

endpackage

// File: rtl/result_fifo.sv
// Small circular FIFO holding (tag, value) results for one execution unit.
// The head is read straight from storage so the arbiter sees it before the edge.
module result_fifo #(
  parameter int DEPTH  = 2,
  parameter int TAG_W  = 3,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              push,
  input  logic [TAG_W-1:0]  push_tag,
  input  logic [DATA_W-1:0] push_value,
  input  logic              pop,
  output logic [TAG_W-1:0]  head_tag,
  output logic [DATA_W-1:0] head_value,
  output logic              empty,
  output logic              full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [TAG_W-1:0]  tag_mem   [DEPTH];
  logic [DATA_W-1:0] value_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic              do_push;
  logic              do_pop;

  // Guard against overflow/underflow locally so callers cannot corrupt state.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign empty      = (count_reg == '0);
  assign full       = (count_reg == CNT_W'(DEPTH));
  assign head_tag   = tag_mem[rd_ptr_reg];
  assign head_value = value_mem[rd_ptr_reg];

  // Pointer and occupancy bookkeeping; DEPTH is a power of two so the
  // pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage write; contents are don't-care while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push && !rst && !clr) begin
      tag_mem[wr_ptr_reg]   <= push_tag;
      value_mem[wr_ptr_reg] <= push_value;
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Shares the single ROB completion port between the ALU and the memory unit:
// one result FIFO per source, a round-robin pick of the FIFO heads each cycle,
// and a registered common data bus carrying the winner.
module cdb_arbiter
  import viola_pkg::*;
#(
  parameter int TAG_W  = viola_pkg::TAG_W,
  parameter int DATA_W = viola_pkg::DATA_W,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              alu_valid,
  input  logic [TAG_W-1:0]  alu_tag,
  input  logic [DATA_W-1:0] alu_value,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [TAG_W-1:0]  mem_tag,
  input  logic [DATA_W-1:0] mem_value,
  output logic              mem_ready,
  output logic [TAG_W-1:0]  cdb_num,
  output logic [DATA_W-1:0] cdb_value,
  output logic              cdb_src,
  output logic              conflict
);

  logic              alu_push, mem_push;
  logic              alu_pop, mem_pop;
  logic              alu_empty, mem_empty;
  logic              alu_full, mem_full;
  logic [TAG_W-1:0]  alu_head_tag, mem_head_tag;
  logic [DATA_W-1:0] alu_head_value, mem_head_value;
  logic              rr_last_reg;
  logic              any_req;
  logic              both_req;
  logic              gnt_src;

  // Ready comes only from registered occupancy: a full FIFO stays not-ready
  // even in a cycle where it is being popped.
  assign alu_ready = !alu_full;
  assign mem_ready = !mem_full;

  // Tag 0 is the idle marker on the bus, so such offers are silently dropped.
  assign alu_push = alu_valid && !alu_full && (alu_tag != TAG_W'(NULL_TAG));
  assign mem_push = mem_valid && !mem_full && (mem_tag != TAG_W'(NULL_TAG));

  assign any_req  = !alu_empty || !mem_empty;
  assign both_req = !alu_empty && !mem_empty;
  assign gnt_src  = pick_src(!alu_empty, !mem_empty, rr_last_reg);

  assign alu_pop = any_req && (gnt_src == SRC_ALU);
  assign mem_pop = any_req && (gnt_src == SRC_MEM);

  result_fifo #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W)) u_alu_fifo (
    .clk        (clk),
    .rst        (rst),
    .clr        (flush),
    .push       (alu_push),
    .push_tag   (alu_tag),
    .push_value (alu_value),
    .pop        (alu_pop),
    .head_tag   (alu_head_tag),
    .head_value (alu_head_value),
    .empty      (alu_empty),
    .full       (alu_full)
  );

  result_fifo #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W)) u_mem_fifo (
    .clk        (clk),
    .rst        (rst),
    .clr        (flush),
    .push       (mem_push),
    .push_tag   (mem_tag),
    .push_value (mem_value),
    .pop        (mem_pop),
    .head_tag   (mem_head_tag),
    .head_value (mem_head_value),
    .empty      (mem_empty),
    .full       (mem_full)
  );

  // Registered CDB and round-robin history; flush leaves cdb_value/src as-is.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_last_reg <= SRC_MEM;
      cdb_num     <= '0;
      cdb_value   <= '0;
      cdb_src     <= SRC_ALU;
      conflict    <= 1'b0;
    end else if (flush) begin
      rr_last_reg <= SRC_MEM;
      cdb_num     <= '0;
      conflict    <= 1'b0;
    end else if (!any_req) begin
      cdb_num  <= '0;
      conflict <= 1'b0;
    end else begin
      conflict <= both_req;
      cdb_src  <= gnt_src;
      if (both_req) rr_last_reg <= gnt_src;
      if (gnt_src == SRC_ALU) begin
        cdb_num   <= alu_head_tag;
        cdb_value <= alu_head_value;
      end else begin
        cdb_num   <= mem_head_tag;
        cdb_value <= mem_head_value;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: a queue-based reference model follows
// every clock, a negedge process compares the DUT against it every cycle, and
// directed scenarios add literal expectations.
module tb_cdb_arbiter;

  localparam int TAG_W  = 3;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 2;

  logic              clk = 1'b0;
  logic              rst, flush;
  logic              alu_valid, mem_valid;
  logic [TAG_W-1:0]  alu_tag, mem_tag;
  logic [DATA_W-1:0] alu_value, mem_value;
  logic              alu_ready, mem_ready;
  logic [TAG_W-1:0]  cdb_num;
  logic [DATA_W-1:0] cdb_value;
  logic              cdb_src;
  logic              conflict;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  cdb_arbiter #(.TAG_W(TAG_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .alu_valid (alu_valid),
    .alu_tag   (alu_tag),
    .alu_value (alu_value),
    .alu_ready (alu_ready),
    .mem_valid (mem_valid),
    .mem_tag   (mem_tag),
    .mem_value (mem_value),
    .mem_ready (mem_ready),
    .cdb_num   (cdb_num),
    .cdb_value (cdb_value),
    .cdb_src   (cdb_src),
    .conflict  (conflict)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] val;
  } ent_t;

  ent_t              aq[$];
  ent_t              mq[$];
  int                m_last = 1;   // 0 = ALU won last conflict, 1 = MEM
  logic [TAG_W-1:0]  e_num  = '0;
  logic [DATA_W-1:0] e_val  = '0;
  logic              e_src  = 1'b0;
  logic              e_conf = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        aq.delete(); mq.delete();
        m_last = 1; e_num = '0; e_val = '0; e_src = 1'b0; e_conf = 1'b0;
      end else if (flush) begin
        aq.delete(); mq.delete();
        m_last = 1; e_num = '0; e_conf = 1'b0;
      end else begin
        bit   a_rdy, m_rdy;
        int   winner;
        ent_t e;
        a_rdy = aq.size() < DEPTH;
        m_rdy = mq.size() < DEPTH;
        winner = -1;
        e_conf = 1'b0;
        if (aq.size() > 0 && mq.size() > 0) begin
          winner = (m_last == 1) ? 0 : 1;
          m_last = winner;
          e_conf = 1'b1;
        end else if (aq.size() > 0) winner = 0;
        else if (mq.size() > 0) winner = 1;
        if (winner == 0) begin
          e = aq.pop_front(); e_num = e.tag; e_val = e.val; e_src = 1'b0;
        end else if (winner == 1) begin
          e = mq.pop_front(); e_num = e.tag; e_val = e.val; e_src = 1'b1;
        end else begin
          e_num = '0;
        end
        if (alu_valid && a_rdy && alu_tag != 0) aq.push_back('{alu_tag, alu_value});
        if (mem_valid && m_rdy && mem_tag != 0) mq.push_back('{mem_tag, mem_value});
      end
    end
  end

  // ---------------- comparison helper ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle compare against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("cdb_num", 64'(cdb_num), 64'(e_num));
        chk("conflict", 64'(conflict), 64'(e_conf));
        chk("alu_ready", 64'(alu_ready), 64'(aq.size() < DEPTH));
        chk("mem_ready", 64'(mem_ready), 64'(mq.size() < DEPTH));
        if (e_num != 0) begin
          chk("cdb_value", 64'(cdb_value), 64'(e_val));
          chk("cdb_src", 64'(cdb_src), 64'(e_src));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_in(input bit av, input int at, input int avl,
                        input bit mv, input int mt, input int mvl, input bit fl);
    alu_valid = av; alu_tag = TAG_W'(at); alu_value = DATA_W'(avl);
    mem_valid = mv; mem_tag = TAG_W'(mt); mem_value = DATA_W'(mvl);
    flush = fl;
  endtask

  task automatic idle(input int n);
    set_in(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    bit seen_full;
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    // reset state
    chk("rst_num", 64'(cdb_num), 64'd0);
    chk("rst_value", 64'(cdb_value), 64'd0);
    chk("rst_src", 64'(cdb_src), 64'd0);
    chk("rst_conflict", 64'(conflict), 64'd0);
    chk("rst_alu_ready", 64'(alu_ready), 64'd1);
    chk("rst_mem_ready", 64'(mem_ready), 64'd1);
    rst = 1'b0;
    chk_en = 1'b1;
    idle(2);
    $display("txn reset+idle done");

    // single ALU result: accepted at E0, on bus after E1 for one cycle
    set_in(1, 3, 32'h10, 0, 0, 0, 0);
    @(negedge clk);
    idle(1);
    chk("single_num", 64'(cdb_num), 64'd3);
    chk("single_value", 64'(cdb_value), 64'h10);
    chk("single_src", 64'(cdb_src), 64'd0);
    idle(1);
    chk("single_gone", 64'(cdb_num), 64'd0);
    $display("txn single alu tag=3");

    // simultaneous results: ALU first, conflict flagged once
    set_in(1, 2, 32'hAAAA, 1, 5, 32'h5555, 0);
    @(negedge clk);
    idle(1);
    chk("simul1_num", 64'(cdb_num), 64'd2);
    chk("simul1_src", 64'(cdb_src), 64'd0);
    chk("simul1_conf", 64'(conflict), 64'd1);
    idle(1);
    chk("simul2_num", 64'(cdb_num), 64'd5);
    chk("simul2_value", 64'(cdb_value), 64'h5555);
    chk("simul2_src", 64'(cdb_src), 64'd1);
    chk("simul2_conf", 64'(conflict), 64'd0);
    idle(2);
    $display("txn simultaneous alu=2 mem=5");

    // sustained contention for 10 cycles
    seen_full = 1'b0;
    for (int i = 0; i < 10; i++) begin
      set_in(1, $urandom_range(1, 7), $urandom, 1, $urandom_range(1, 7), $urandom, 0);
      @(negedge clk);
      if (!alu_ready || !mem_ready) seen_full = 1'b1;
      $display("txn contention cycle=%0d cdb_num=%0d src=%0d", i, cdb_num, cdb_src);
    end
    chk("contention_full_seen", 64'(seen_full), 64'd1);
    idle(6);

    // tag 0 filter
    set_in(1, 0, 32'hDEAD, 0, 0, 0, 0);
    @(negedge clk);
    idle(1);
    chk("tag0_idle", 64'(cdb_num), 64'd0);
    idle(1);
    chk("tag0_idle2", 64'(cdb_num), 64'd0);
    $display("txn tag0 ignored");

    // flush mid-stream
    set_in(1, 1, 32'h11, 1, 6, 32'h66, 0);
    @(negedge clk);
    set_in(1, 4, 32'h44, 0, 0, 0, 1);
    @(negedge clk);
    chk("flush_num", 64'(cdb_num), 64'd0);
    idle(3);
    chk("flush_after", 64'(cdb_num), 64'd0);
    chk("flush_ready", 64'(alu_ready), 64'd1);
    set_in(0, 0, 0, 1, 7, 32'h77, 0);
    @(negedge clk);
    idle(1);
    chk("post_flush_num", 64'(cdb_num), 64'd7);
    chk("post_flush_src", 64'(cdb_src), 64'd1);
    idle(2);
    $display("txn flush then mem tag=7");

    // randomized traffic with occasional flush and reset
    for (int i = 0; i < 400; i++) begin
      set_in($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom,
             $urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom,
             $urandom_range(0, 39) == 0);
      rst = ($urandom_range(0, 99) == 0);
      @(negedge clk);
      $display("txn rand=%0d cdb_num=%0d src=%0d conflict=%0d", i, cdb_num, cdb_src, conflict);
    end
    rst = 1'b0;
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
